// File: rtl/ro_freq_meter.sv
// Ring-oscillator frequency meter: counts rising edges of an asynchronous
// input over a fixed window of 2^GATE_W clk cycles, latches the result and
// offers it both in parallel and as an MSB-first serial stream.
module ro_freq_meter #(
  parameter int GATE_W = 10,
  parameter int CNT_W  = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             meas_in,
  input  logic             start,
  input  logic             shift_en,
  output logic             busy,
  output logic             done,
  output logic             ovf,
  output logic [CNT_W-1:0] count,
  output logic             ser_out
);

  typedef enum logic [1:0] {
    IDLE,
    ARM,
    MEASURE,
    DONE
  } state_t;

  state_t state;
  state_t state_next;

  logic              s1;
  logic              s2;
  logic              s3;
  logic              arm_cnt;
  logic [GATE_W-1:0] gate_cnt;
  logic [CNT_W-1:0]  edge_cnt;
  logic [CNT_W-1:0]  edge_cnt_inc;
  logic [CNT_W-1:0]  readout;
  logic              edge_det;
  logic              accept;
  logic              gate_last;
  logic              cnt_sat;

  assign edge_det  = s2 & ~s3;
  assign accept    = start & ((state == IDLE) | (state == DONE));
  assign gate_last = &gate_cnt;
  assign cnt_sat   = &edge_cnt;

  // Saturating next value of the edge counter; it holds at all-ones rather than wrapping.
  assign edge_cnt_inc = (edge_det && !cnt_sat) ? edge_cnt + CNT_W'(1) : edge_cnt;

  assign busy    = (state == ARM) | (state == MEASURE);
  assign done    = (state == DONE);
  assign ser_out = readout[CNT_W-1];

  // Two-flop synchronizer plus history flop for edge detection; runs in every state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      s1 <= meas_in;
      s2 <= s1;
      s3 <= s2;
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic: ARM holds for two cycles, MEASURE until the gate counter is all-ones.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start)     state_next = ARM;
      ARM:     if (arm_cnt)   state_next = MEASURE;
      MEASURE: if (gate_last) state_next = DONE;
      DONE:    if (start)     state_next = ARM;
      default:                state_next = IDLE;
    endcase
  end

  // Measurement datapath: clears on an accepted start (which beats shift_en), counts
  // during MEASURE including the final gate cycle, then latches and shifts out in DONE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      arm_cnt  <= 1'b0;
      gate_cnt <= '0;
      edge_cnt <= '0;
      ovf      <= 1'b0;
      count    <= '0;
      readout  <= '0;
    end else if (accept) begin
      arm_cnt  <= 1'b0;
      gate_cnt <= '0;
      edge_cnt <= '0;
      ovf      <= 1'b0;
      count    <= '0;
      readout  <= '0;
    end else begin
      case (state)
        ARM: begin
          arm_cnt <= 1'b1;
        end
        MEASURE: begin
          gate_cnt <= gate_cnt + GATE_W'(1);
          edge_cnt <= edge_cnt_inc;
          if (edge_det && cnt_sat) begin
            ovf <= 1'b1;
          end
          if (gate_last) begin
            count   <= edge_cnt_inc;
            readout <= edge_cnt_inc;
          end
        end
        DONE: begin
          if (shift_en) begin
            readout <= {readout[CNT_W-2:0], 1'b0};
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ro_freq_meter.sv
// Directed testbench for ro_freq_meter: three instances cover the nominal
// window, counter saturation and the serial readout path.
module tb_ro_freq_meter;

  logic        clk;
  logic        rst_n;
  logic        meas_in;
  logic        meas_ser;
  int          meas_mode;
  int          phase;

  logic        start;
  logic        shift_en;
  logic        busy;
  logic        done;
  logic        ovf;
  logic [15:0] count;
  logic        ser_out;

  logic        start_sat;
  logic        shift_sat;
  logic        busy_sat;
  logic        done_sat;
  logic        ovf_sat;
  logic [3:0]  count_sat;
  logic        ser_sat;

  logic        start_ser;
  logic        shift_ser;
  logic        busy_ser;
  logic        done_ser;
  logic        ovf_ser;
  logic [7:0]  count_ser;
  logic        ser_ser;

  int          vectors;
  int          miscompares;

  ro_freq_meter #(.GATE_W(6), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .meas_in(meas_in), .start(start), .shift_en(shift_en),
    .busy(busy), .done(done), .ovf(ovf), .count(count), .ser_out(ser_out)
  );

  ro_freq_meter #(.GATE_W(6), .CNT_W(4)) dut_sat (
    .clk(clk), .rst_n(rst_n), .meas_in(meas_in), .start(start_sat), .shift_en(shift_sat),
    .busy(busy_sat), .done(done_sat), .ovf(ovf_sat), .count(count_sat), .ser_out(ser_sat)
  );

  ro_freq_meter #(.GATE_W(9), .CNT_W(8)) dut_ser (
    .clk(clk), .rst_n(rst_n), .meas_in(meas_ser), .start(start_ser), .shift_en(shift_ser),
    .busy(busy_ser), .done(done_ser), .ovf(ovf_ser), .count(count_ser), .ser_out(ser_ser)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Oscillator model: changes on the falling clk edge so it never races the sampling edge.
  // Mode 0 = held low, 1 = held high, 2 = period 8 clk, 3 = period 2 clk.
  always @(negedge clk) begin
    phase <= phase + 1;
    case (meas_mode)
      0:       meas_in <= 1'b0;
      1:       meas_in <= 1'b1;
      2:       meas_in <= phase[2];
      default: meas_in <= phase[0];
    endcase
  end

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // Starts a measurement on the main instance and returns the number of clk edges from
  // the start edge until done rises; optionally re-pulses start mid-measurement.
  task automatic applyStimulus(input int extra_at, output int lat);
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("busy_after_start", {31'd0, busy}, 32'd1);
    checkOutput("done_after_start", {31'd0, done}, 32'd0);
    start = 1'b0;
    lat = 0;
    while (!done && lat < 200) begin
      @(posedge clk);
      #1;
      lat++;
      start = (lat == extra_at);
    end
    start = 1'b0;
  endtask

  logic [7:0] exp_ser;
  int         lat;

  initial begin
    vectors     = 0;
    miscompares = 0;
    phase       = 0;
    meas_mode   = 1;
    meas_in     = 1'b1;
    meas_ser    = 1'b0;
    start       = 1'b0;
    shift_en    = 1'b0;
    start_sat   = 1'b0;
    shift_sat   = 1'b0;
    start_ser   = 1'b0;
    shift_ser   = 1'b0;
    exp_ser     = 8'hA5;

    rst_n = 1'b0;
    repeat (4) @(negedge clk);
    checkOutput("reset_busy", {31'd0, busy}, 32'd0);
    checkOutput("reset_done", {31'd0, done}, 32'd0);
    checkOutput("reset_ovf", {31'd0, ovf}, 32'd0);
    checkOutput("reset_count", {16'd0, count}, 32'd0);
    checkOutput("reset_ser_out", {31'd0, ser_out}, 32'd0);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    // Input held high since before reset: no edge may be counted.
    applyStimulus(-1, lat);
    checkOutput("held1_latency", lat, 32'd66);
    checkOutput("held1_count", {16'd0, count}, 32'd0);

    // Input held low.
    meas_mode = 0;
    applyStimulus(-1, lat);
    checkOutput("held0_count", {16'd0, count}, 32'd0);

    // Period-8 square wave: 64-cycle window holds exactly 8 rising edges.
    meas_mode = 2;
    repeat (5) @(negedge clk);
    applyStimulus(-1, lat);
    checkOutput("freq_latency", lat, 32'd66);
    checkOutput("freq_count", {16'd0, count}, 32'd8);
    checkOutput("freq_ovf", {31'd0, ovf}, 32'd0);
    checkOutput("freq_busy", {31'd0, busy}, 32'd0);
    checkOutput("freq_done", {31'd0, done}, 32'd1);

    // Start re-pulsed mid-measurement is ignored.
    applyStimulus(30, lat);
    checkOutput("ignored_start_latency", lat, 32'd66);
    checkOutput("ignored_start_count", {16'd0, count}, 32'd8);
    repeat (3) @(negedge clk);
    checkOutput("ignored_start_stays_done", {31'd0, done}, 32'd1);

    // Period-2 input, 4-bit counter: 32 edges saturate at 15 and flag overflow.
    meas_mode = 3;
    repeat (5) @(negedge clk);
    start_sat = 1'b1;
    @(negedge clk);
    start_sat = 1'b0;
    lat = 0;
    while (!done_sat && lat < 200) begin
      @(negedge clk);
      lat++;
    end
    checkOutput("sat_done", {31'd0, done_sat}, 32'd1);
    checkOutput("sat_count", {28'd0, count_sat}, 32'd15);
    checkOutput("sat_ovf", {31'd0, ovf_sat}, 32'd1);
    start_sat = 1'b1;
    @(negedge clk);
    start_sat = 1'b0;
    checkOutput("sat_restart_ovf", {31'd0, ovf_sat}, 32'd0);
    checkOutput("sat_restart_count", {28'd0, count_sat}, 32'd0);
    checkOutput("sat_restart_busy", {31'd0, busy_sat}, 32'd1);
    lat = 0;
    while (!done_sat && lat < 200) begin
      @(negedge clk);
      lat++;
    end
    checkOutput("sat_rerun_ovf", {31'd0, ovf_sat}, 32'd1);

    // Serial readout: exactly 165 (0xA5) pulses inside a 512-cycle window.
    start_ser = 1'b1;
    @(negedge clk);
    start_ser = 1'b0;
    repeat (20) @(negedge clk);
    for (int p = 0; p < 165; p++) begin
      meas_ser = 1'b1;
      @(negedge clk);
      meas_ser = 1'b0;
      @(negedge clk);
    end
    lat = 0;
    while (!done_ser && lat < 600) begin
      @(negedge clk);
      lat++;
    end
    checkOutput("ser_done", {31'd0, done_ser}, 32'd1);
    checkOutput("ser_count", {24'd0, count_ser}, 32'hA5);
    checkOutput("ser_ovf", {31'd0, ovf_ser}, 32'd0);
    for (int b = 0; b < 8; b++) begin
      checkOutput($sformatf("ser_bit%0d", b), {31'd0, ser_ser}, {31'd0, exp_ser[7-b]});
      shift_ser = 1'b1;
      @(negedge clk);
      shift_ser = 1'b0;
      @(negedge clk);
    end
    checkOutput("ser_drained", {31'd0, ser_ser}, 32'd0);
    checkOutput("ser_count_kept", {24'd0, count_ser}, 32'hA5);

    // Reset mid-measurement aborts immediately; a fresh run still counts correctly.
    meas_mode = 2;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (20) @(negedge clk);
    checkOutput("abort_busy_before", {31'd0, busy}, 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("abort_busy", {31'd0, busy}, 32'd0);
    checkOutput("abort_done", {31'd0, done}, 32'd0);
    checkOutput("abort_count", {16'd0, count}, 32'd0);
    checkOutput("abort_sat_ovf", {31'd0, ovf_sat}, 32'd0);
    checkOutput("abort_ser_done", {31'd0, done_ser}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    applyStimulus(-1, lat);
    checkOutput("post_abort_latency", lat, 32'd66);
    checkOutput("post_abort_count", {16'd0, count}, 32'd8);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/ro_freq_meter.md
Name: ro_freq_meter

Overview:
- Downstream consumer of the ring-oscillator / clock-select stage.
- Measures the selected, divided oscillator output (`meas_in`, asynchronous to `clk`) by counting its rising edges over a fixed gate window of `clk` cycles.
- Latches the result and exposes it both in parallel and as an MSB-first serial stream for the 8-pin I/O.
- Lets a tester read oscillator frequency directly instead of watching free-running counter bits.

Parameters:
- `GATE_W`, 10: gate window is exactly 2^`GATE_W` `clk` cycles.
- `CNT_W`, 16: width of the edge counter and of the result.

Ports:
- `clk`  input  1  single block clock; all state is on its rising edge.
- `rst_n`  input  1  asynchronous active-low reset.
- `meas_in`  input  1  signal under measurement; asynchronous to `clk`.
- `start`  input  1  measurement request; level sampled each `clk` edge.
- `shift_en`  input  1  advances the serial readout by one bit; synchronous.
- `busy`  output  1  high while in ARM or MEASURE.
- `done`  output  1  high in DONE; result valid.
- `ovf`  output  1  sticky: edge count exceeded 2^`CNT_W`-1 during the last measurement.
- `count`  output  `CNT_W`  latched edge count.
- `ser_out`  output  1  current serial bit, which is the MSB of the readout shift register.

Behaviour:
- Reset (`rst_n`=0, asynchronous) forces the following, regardless of `clk`:
  - state = IDLE
  - sync flops, edge flop, gate counter, edge counter, readout register all = 0
  - `busy`=0, `done`=0, `ovf`=0, `count`=0, `ser_out`=0
- Input path:
  - `meas_in` passes through a 2-flop synchronizer (s1→s2), then a history flop s3.
  - Rising edge detected = s2 & ~s3.
  - The synchronizer and s3 run in every state.
- States:
  - IDLE: `start`=1 → ARM; clear edge counter, gate counter, `ovf`, `count`, readout register.
  - ARM: lasts exactly 2 cycles; the edge detect is ignored, which flushes stale synchronizer contents. It then goes → MEASURE.
  - MEASURE: lasts exactly 2^`GATE_W` cycles, and the gate counter (`GATE_W` bits) increments each cycle.
    - Each cycle with a detected edge increments the edge counter.
    - On the cycle the gate counter reaches all-ones, that cycle's edge is still counted. The final value is latched into `count` and the readout register, and the state goes → DONE.
  - DONE: `done`=1. `start`=1 → ARM, with the same clearing as from IDLE; `done` drops on that edge.
- Timing:
  - If `start` is sampled at edge k, then `busy`=1 after edge k.
  - Edges k+1 and k+2 are ARM.
  - Edges k+3 … k+2+2^`GATE_W` are the counted MEASURE samples.
  - `done`=1 and `busy`=0 after edge k+2+2^`GATE_W`.
- `start` while `busy`=1 is ignored; no restart and no queueing.
- Saturation:
  - The edge counter saturates at 2^`CNT_W`-1 and never wraps.
  - Any edge detected while the counter is saturated sets `ovf`.
  - `ovf` is reported with the result and cleared on the next accepted `start`.
- Readout:
  - `ser_out` = MSB of the readout register.
  - In DONE, `shift_en`=1 shifts the register left by 1 and fills with 0.
  - After `CNT_W` shifts `ser_out`=0.
  - `shift_en` outside DONE is ignored.
  - `count` is not affected by shifting.
- Maximum measurable rate: `meas_in` high and low phases must each be ≥1 `clk` period. Faster input gives an undercount; this is a user constraint, not detected by the block.
- Reset mid-MEASURE aborts the measurement and returns to IDLE with all outputs 0. No partial result is retained.
- Simultaneous `start` and `shift_en` in DONE: `start` wins. The readout register is cleared and the state goes → ARM.

Test Plan:
- Frequency count: `GATE_W`=6, `CNT_W`=16, `meas_in` square wave of period 8 `clk` (4 high / 4 low, edges offset from `clk`), pulse `start` → `done` 66 edges after start edge, `count`=8, `ovf`=0, `busy`=0.
- No false edge: `meas_in` held 1 from before reset, `start` → `count`=0. Repeat with `meas_in` held 0 → `count`=0.
- Saturation: `CNT_W`=4, `GATE_W`=6, `meas_in` period 2 `clk` → `count`=15, `ovf`=1. Next `start` → `ovf`=0, `count`=0 during ARM.
- Serial readout: `count`=16'hA5C3 in DONE, apply 16 single-cycle `shift_en` pulses → `ser_out` sequence 1010_0101_1100_0011, then 0. `count` unchanged.
- Ignored start and abort: `start` pulsed again mid-MEASURE → `done` timing unchanged and `count` correct. Separately, drive `rst_n`=0 mid-MEASURE → all outputs 0 immediately, state IDLE, and a new `start` yields a correct full-window count.
